buf_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined inverter chain (the hierarchical buffer datapath) among `NREQ` requesters. Each cycle it grants at most one requester and launches that requester's data and ID into a `STAGES`-deep registered chain. Every stage inverts the data. The result is returned to the owning requester after exactly `STAGES` cycles. It sits between the requester blocks and the shared buffer/inverter datapath, and owns all sequencing and in-flight tracking for that datapath.

---
 rtl/buf_share_pkg.sv | 35 +++
 rtl/buf_share_stage.sv | 35 +++
 rtl/buf_share_arbiter.sv | 113 +++++++++++
 tb/tb_buf_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_share_pkg.sv
// Shared types and helpers for the buffer-sharing arbiter.
package buf_share_pkg;

    localparam int NREQ_MAX = 16;
    localparam int ID_W_MAX = 4;

    // Result of a round-robin search: winner index plus a found flag.
    typedef struct packed {
        logic                found;
        logic [ID_W_MAX-1:0] idx;
    } pick_t;

    // Requester ID width; a single bit is kept even for two requesters.
    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // First requester found searching ptr, ptr+1, ... modulo nreq.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                      input logic [ID_W_MAX-1:0] ptr,
                                      input int                  nreq);
        pick_t p;
        int    cand;
        p = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            cand = (int'(ptr) + k) % nreq;
            if (k < nreq && !p.found && req[cand[ID_W_MAX-1:0]]) begin
                p.found = 1'b1;
                p.idx   = cand[ID_W_MAX-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/buf_share_stage.sv
// One registered inverting stage of the shared datapath, carrying {v, id, d}.
module buf_share_stage
    import buf_share_pkg::*;
#(
    parameter int ID_W = 2,
    parameter int W    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            v_in,
    input  logic [ID_W-1:0] id_in,
    input  logic [W-1:0]    d_in,
    output logic            v_out,
    output logic [ID_W-1:0] id_out,
    output logic [W-1:0]    d_out
);

    // Capture the upstream entry (inverting data); flush kills valid but keeps id/d.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_out  <= 1'b0;
            id_out <= '0;
            d_out  <= '0;
        end else begin
            v_out <= load & v_in & ~flush;
            if (load && !flush) begin
                id_out <= id_in;
                d_out  <= ~d_in;
            end
        end
    end

endmodule

// File: rtl/buf_share_arbiter.sv
// Round-robin arbiter feeding a shared STAGES-deep inverter chain; returns
// each result to its owning requester STAGES cycles after the grant.
module buf_share_arbiter
    import buf_share_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] din,
    input  logic            flush,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rsp_valid,
    output logic [W-1:0]    rsp_data,
    output logic            busy
);

    localparam int ID_W = id_width(NREQ);

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_nxt;
    logic [ID_W-1:0]     winner;
    logic [NREQ_MAX-1:0] req_ext;
    pick_t               pick;
    logic                grant;
    logic [W-1:0]        dsel;

    logic            vld_p  [STAGES];
    logic [ID_W-1:0] id_p   [STAGES];
    logic [W-1:0]    d_p    [STAGES];
    logic            load_in[STAGES];
    logic            vld_in [STAGES];
    logic [ID_W-1:0] id_in  [STAGES];
    logic [W-1:0]    d_in   [STAGES];

    // Zero-extend the request vector to the search function's fixed width.
    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign pick    = rr_pick(req_ext, ID_W_MAX'(ptr), NREQ);
    assign winner  = ID_W'(pick.idx);
    assign grant   = pick.found & ~flush;
    assign ptr_nxt = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Grant decode and winner data mux.
    always_comb begin
        gnt  = '0;
        dsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                dsel = din[i*W +: W];
                if (grant) gnt[i] = 1'b1;
            end
        end
    end

    // Pointer advances past the winner on every grant.
    always_ff @(posedge clk) begin
        if (reset)      ptr <= '0;
        else if (grant) ptr <= ptr_nxt;
    end

    // Stage inputs: stage 0 loads only on a grant, later stages shift every cycle.
    always_comb begin
        load_in[0] = grant;
        vld_in[0]  = grant;
        id_in[0]   = winner;
        d_in[0]    = dsel;
        for (int k = 1; k < STAGES; k++) begin
            load_in[k] = 1'b1;
            vld_in[k]  = vld_p[k-1];
            id_in[k]   = id_p[k-1];
            d_in[k]    = d_p[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        buf_share_stage #(
            .ID_W(ID_W),
            .W   (W)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (load_in[k]),
            .v_in  (vld_in[k]),
            .id_in (id_in[k]),
            .d_in  (d_in[k]),
            .v_out (vld_p[k]),
            .id_out(id_p[k]),
            .d_out (d_p[k])
        );
    end

    // Response decode from the last stage, and chain occupancy.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = d_p[STAGES-1];
        busy      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (vld_p[STAGES-1] && id_p[STAGES-1] == ID_W'(i)) rsp_valid[i] = 1'b1;
        end
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | vld_p[k];
        end
    end

endmodule

// File: tb/tb_buf_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-indexed response schedule model.
module tb_buf_share_arbiter;

    localparam int N  = 4;
    localparam int SA = 2;
    localparam int WA = 1;
    localparam int SB = 3;
    localparam int WB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    req_a, gnt_a, rv_a;
    logic [N*WA-1:0] din_a;
    logic            flush_a, busy_a;
    logic [WA-1:0]   rd_a;

    logic [N-1:0]    req_b, gnt_b, rv_b;
    logic [N*WB-1:0] din_b;
    logic            flush_b, busy_b;
    logic [WB-1:0]   rd_b;

    buf_share_arbiter #(.NREQ(N), .STAGES(SA), .W(WA)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .din(din_a), .flush(flush_a),
        .gnt(gnt_a), .rsp_valid(rv_a), .rsp_data(rd_a), .busy(busy_a)
    );

    buf_share_arbiter #(.NREQ(N), .STAGES(SB), .W(WB)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .din(din_b), .flush(flush_b),
        .gnt(gnt_b), .rsp_valid(rv_b), .rsp_data(rd_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: round-robin pointer and responses scheduled by due cycle.
    int            mptr = 0;
    logic          slot_v  [8];
    int            slot_id [8];
    logic [WA-1:0] slot_d  [8];

    logic [N-1:0]  obs_gnt, obs_rv;
    logic [WA-1:0] obs_rd;
    logic          obs_busy;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
    endtask

    // One clock of DUT A: drive, check mid-cycle against model, advance model.
    task automatic step(input logic [N-1:0] r, input logic [N*WA-1:0] d,
                        input logic f, input logic rst);
        int            w;
        logic [N-1:0]  eg, erv;
        logic          eb;
        req_a = r; din_a = d; flush_a = f; reset = rst;
        #3;
        w  = pick(r, mptr);
        eg = '0;
        if (w >= 0 && !f) eg[w] = 1'b1;
        erv = '0;
        if (slot_v[cyc % 8]) erv[slot_id[cyc % 8]] = 1'b1;
        eb = 1'b0;
        for (int k = 0; k < SA; k++) if (slot_v[(cyc + k) % 8]) eb = 1'b1;
        obs_gnt = gnt_a; obs_rv = rv_a; obs_rd = rd_a; obs_busy = busy_a;
        checks++;
        if (gnt_a !== eg) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt_a, eg);
        end
        checks++;
        if (rv_a !== erv) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rv_a, erv);
        end
        checks++;
        if (busy_a !== eb) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_a, eb);
        end
        if (erv != 0) begin
            checks++;
            if (rd_a !== slot_d[cyc % 8]) begin
                errors++;
                $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rd_a, slot_d[cyc % 8]);
            end
        end
        slot_v[cyc % 8] = 1'b0;
        if (rst) begin
            clear_model();
            mptr = 0;
        end else begin
            if (f) clear_model();
            if (eg != 0) begin
                slot_v[(cyc + SA) % 8]  = 1'b1;
                slot_id[(cyc + SA) % 8] = w;
                slot_d[(cyc + SA) % 8]  = (SA % 2 == 0) ? d[w*WA +: WA] : ~d[w*WA +: WA];
                mptr = (w + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step('0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_rd !== '0) begin
            errors++;
            $display("FAIL reset_rsp_data got=%h exp=0", obs_rd);
        end
        checks++;
        if (gnt_b !== '0 || rv_b !== '0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut_b got=%b/%b/%b exp=0/0/0", gnt_b, rv_b, busy_b);
        end
    endtask

    task automatic test_single();
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        checks++;
        if (obs_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_gnt got=%b exp=0100", obs_gnt);
        end
        step('0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy got=%b exp=1", obs_busy);
        end
        step('0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_rv !== 4'b0100 || obs_rd !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp got=%b/%b exp=0100/1", obs_rv, obs_rd);
        end
        step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_all_requesting();
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            checks++;
            if (obs_gnt !== 4'(1 << (i % N))) begin
                errors++;
                $display("FAIL fair_gnt i=%0d got=%b exp=%b", i, obs_gnt, 4'(1 << (i % N)));
            end
        end
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 4'b0011, 1'b0, 1'b0);
            checks++;
            if (obs_gnt !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap_gnt i=%0d got=%b exp=%b", i, obs_gnt, exp_seq[i]);
            end
        end
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        step(4'b1111, 4'b1010, 1'b1, 1'b0);
        checks++;
        if (obs_gnt !== '0) begin
            errors++;
            $display("FAIL flush_gnt got=%b exp=0000", obs_gnt);
        end
        step('0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_busy !== 1'b0 || obs_rv !== '0) begin
            errors++;
            $display("FAIL flush_drain got=%b/%b exp=0/0000", obs_busy, obs_rv);
        end
        step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midflight();
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b0, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b0);
        checks++;
        if (obs_gnt !== 4'b0001 || obs_rv !== '0) begin
            errors++;
            $display("FAIL rst_mid got=%b/%b exp=0001/0000", obs_gnt, obs_rv);
        end
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    // Odd chain on DUT B: 0xA into requester 1 returns 0x5 three cycles later.
    task automatic test_odd_chain();
        req_a = '0; din_a = '0; flush_a = 1'b0; reset = 1'b0;
        req_b = 4'b0010; din_b = 16'h00A0;
        #3;
        checks++;
        if (gnt_b !== 4'b0010) begin
            errors++;
            $display("FAIL odd_gnt got=%b exp=0010", gnt_b);
        end
        @(posedge clk); #1;
        req_b = '0; din_b = '0;
        for (int k = 1; k <= SB; k++) begin
            #3;
            checks++;
            if (rv_b !== ((k == SB) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL odd_rv k=%0d got=%b", k, rv_b);
            end
            if (k == SB) begin
                checks++;
                if (rd_b !== 4'h5) begin
                    errors++;
                    $display("FAIL odd_data got=%h exp=5", rd_b);
                end
            end
            @(posedge clk); #1;
        end
        cyc += SB + 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_model();
        reset = 1'b1; req_a = '0; din_a = '0; flush_a = 1'b0;
        req_b = '0; din_b = '0; flush_b = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap();
        test_flush();
        test_reset_midflight();
        test_odd_chain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
